// File: rtl/reg_reader_pkg.sv
// reg_reader_pkg: FSM state encoding and settle-counter width shared by the register bank reader
package reg_reader_pkg;
  localparam int SETTLE_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, SELECT, CAPTURE, RESP} state_e;
endpackage

// File: rtl/reg_reader_settle_cnt.sv
// reg_reader_settle_cnt: loadable down-counter timing the chip-select settle window
//   clk, rst_n (async active-low) | load, load_val: preset | dec: enabled decrement | zero: count is 0
module reg_reader_settle_cnt
  import reg_reader_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic                    dec,
  input  logic [SETTLE_CNT_W-1:0] load_val,
  output logic                    zero
);
  logic [SETTLE_CNT_W-1:0] cnt_q, cnt_d;
  assign zero = cnt_q == '0;
  always_comb cnt_d = load ? load_val : (dec && !zero) ? cnt_q - 1'b1 : cnt_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= '0;
    else cnt_q <= cnt_d;
endmodule

// File: rtl/register_bank_reader.sv
// register_bank_reader: reads one of NrOfSlots tri-state registers over a shared bus
//   Clock, Reset (async active-low), ClockEnable & Tick qualify every state advance
//   ReqValid/ReqSlot/ReqReady: request | CsN: active-low selects | BusIn: shared bus
//   RspValid/RspData/RspReady: response | Busy: not idle
//   REG_READER_SLOT_ERR_EN adds RspErr; out-of-range slots then answer at once with an error
module register_bank_reader
  import reg_reader_pkg::*;
#(
  parameter int NrOfBits     = 32,
  parameter int NrOfSlots    = 4,
  parameter int SettleCycles = 1
) (
  input  logic                         Clock,
  input  logic                         Reset,
  input  logic                         ClockEnable,
  input  logic                         Tick,
  input  logic                         ReqValid,
  input  logic [$clog2(NrOfSlots)-1:0] ReqSlot,
  output logic                         ReqReady,
  output logic [NrOfSlots-1:0]         CsN,
  input  logic [NrOfBits-1:0]          BusIn,
  output logic                         RspValid,
  output logic [NrOfBits-1:0]          RspData,
  input  logic                         RspReady,
`ifdef REG_READER_SLOT_ERR_EN
  output logic                         RspErr,
`endif
  output logic                         Busy
);
  localparam int SW = $clog2(NrOfSlots);
  // counter counts down to zero, so SELECT lasts exactly SettleCycles enabled cycles
  localparam logic [SETTLE_CNT_W-1:0] SETTLE_LOAD = SETTLE_CNT_W'(SettleCycles - 1);
  state_e              state_q, state_d;
  logic [SW-1:0]       slot_q, slot_d;
  logic [NrOfBits-1:0] data_q, data_d;
  logic                run_q, en, accept, bad, settle_done;
  assign en     = ClockEnable & Tick;
  assign accept = en & ReqValid & ReqReady;
`ifdef REG_READER_SLOT_ERR_EN
  logic err_q, err_d;
  assign bad    = {1'b0, ReqSlot} >= (SW+1)'(NrOfSlots);
  assign RspErr = err_q;
`else
  assign bad = 1'b0;
`endif
  reg_reader_settle_cnt u_settle (
    .clk      (Clock),
    .rst_n    (Reset),
    .load     (accept),
    .dec      (en && state_q == SELECT),
    .load_val (SETTLE_LOAD),
    .zero     (settle_done)
  );
  // run_q holds ReqReady low until the first edge after reset release
  always_ff @(posedge Clock or negedge Reset)
    if (!Reset) begin
      state_q <= IDLE;
      slot_q  <= '0;
      data_q  <= '0;
      run_q   <= 1'b0;
`ifdef REG_READER_SLOT_ERR_EN
      err_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      slot_q  <= slot_d;
      data_q  <= data_d;
      run_q   <= 1'b1;
`ifdef REG_READER_SLOT_ERR_EN
      err_q   <= err_d;
`endif
    end
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    state_d = accept ? (bad ? RESP : SELECT) : IDLE;
      SELECT:  state_d = en && settle_done ? CAPTURE : SELECT;
      CAPTURE: state_d = en ? RESP : CAPTURE;
      RESP:    state_d = en && RspReady ? IDLE : RESP;
      default: state_d = IDLE;
    endcase
  end
  always_comb begin
    slot_d = accept ? ReqSlot : slot_q;
    data_d = (en && state_q == CAPTURE) ? BusIn : (accept && bad) ? '0 : data_q;
`ifdef REG_READER_SLOT_ERR_EN
    err_d  = accept ? bad : err_q;
`endif
  end
  // an out-of-range latched slot matches no bit, leaving every select high
  always_comb begin
    ReqReady = run_q && state_q == IDLE;
    Busy     = state_q != IDLE;
    RspValid = state_q == RESP;
    RspData  = data_q;
    for (int i = 0; i < NrOfSlots; i++)
      CsN[i] = !((state_q == SELECT || state_q == CAPTURE) && slot_q == SW'(i));
  end
endmodule

// File: tb/tb_register_bank_reader.sv
// tb_register_bank_reader: directed checks on a 4-slot/settle-1 reader and a 3-slot/settle-3 reader
module tb_register_bank_reader;
  logic        clk = 1'b0, rst_n = 1'b0, ce = 1'b1, tick = 1'b1;
  logic        req_valid_a = 1'b0, req_valid_b = 1'b0, rsp_ready = 1'b0;
  logic [1:0]  req_slot = '0;
  logic [31:0] bus = '0;
  logic        a_req_ready, a_rsp_valid, a_busy, b_req_ready, b_rsp_valid, b_busy;
  logic [3:0]  a_cs_n;
  logic [2:0]  b_cs_n;
  logic [31:0] a_rsp_data, b_rsp_data;
`ifdef REG_READER_SLOT_ERR_EN
  logic        a_rsp_err, b_rsp_err;
`endif
  int tests = 0, fails = 0, onehot_viol = 0;

  always #5 clk = ~clk;

  register_bank_reader #(.NrOfBits(32), .NrOfSlots(4), .SettleCycles(1)) dut_a (
    .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Tick(tick),
    .ReqValid(req_valid_a), .ReqSlot(req_slot), .ReqReady(a_req_ready),
    .CsN(a_cs_n), .BusIn(bus), .RspValid(a_rsp_valid), .RspData(a_rsp_data),
    .RspReady(rsp_ready),
`ifdef REG_READER_SLOT_ERR_EN
    .RspErr(a_rsp_err),
`endif
    .Busy(a_busy)
  );

  register_bank_reader #(.NrOfBits(32), .NrOfSlots(3), .SettleCycles(3)) dut_b (
    .Clock(clk), .Reset(rst_n), .ClockEnable(ce), .Tick(tick),
    .ReqValid(req_valid_b), .ReqSlot(req_slot), .ReqReady(b_req_ready),
    .CsN(b_cs_n), .BusIn(bus), .RspValid(b_rsp_valid), .RspData(b_rsp_data),
    .RspReady(rsp_ready),
`ifdef REG_READER_SLOT_ERR_EN
    .RspErr(b_rsp_err),
`endif
    .Busy(b_busy)
  );

  always @(negedge clk)
    assert ($countones(~a_cs_n) <= 1 && $countones(~b_cs_n) <= 1) else onehot_viol++;

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    tests++; if (a_cs_n !== 4'b1111) begin fails++; $display("FAIL reset_cs_n got %b want 1111", a_cs_n); end
    tests++; if (a_rsp_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp_valid got %b want 0", a_rsp_valid); end
    tests++; if (a_rsp_data !== 32'h0) begin fails++; $display("FAIL reset_rsp_data got %h want 0", a_rsp_data); end
    tests++; if (a_busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b want 0", a_busy); end
    tests++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL reset_req_ready got %b want 0", a_req_ready); end
    tests++; if (b_cs_n !== 3'b111) begin fails++; $display("FAIL reset_cs_n_b got %b want 111", b_cs_n); end
    rst_n = 1'b1;
    #2;
    tests++; if (a_req_ready !== 1'b0) begin fails++; $display("FAIL release_req_ready_early got %b want 0", a_req_ready); end
    cyc();
    tests++; if (a_req_ready !== 1'b1 || b_req_ready !== 1'b1) begin fails++; $display("FAIL release_req_ready got %b%b want 11", a_req_ready, b_req_ready); end
  endtask

  task automatic test_basic();
    req_slot = 2'd2; bus = 32'hDEADBEEF; req_valid_a = 1'b1; rsp_ready = 1'b0;
    cyc();
    req_valid_a = 1'b0;
    tests++; if (a_cs_n !== 4'b1011) begin fails++; $display("FAIL basic_select_cs got %b want 1011", a_cs_n); end
    tests++; if (a_busy !== 1'b1 || a_req_ready !== 1'b0) begin fails++; $display("FAIL basic_busy got busy=%b rdy=%b want 1 0", a_busy, a_req_ready); end
    cyc();
    tests++; if (a_cs_n !== 4'b1011 || a_rsp_valid !== 1'b0) begin fails++; $display("FAIL basic_capture got cs=%b v=%b want 1011 0", a_cs_n, a_rsp_valid); end
    cyc();
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hDEADBEEF) begin fails++; $display("FAIL basic_rsp got v=%b d=%h want 1 deadbeef", a_rsp_valid, a_rsp_data); end
    tests++; if (a_cs_n !== 4'b1111) begin fails++; $display("FAIL basic_rsp_cs got %b want 1111", a_cs_n); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    tests++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin fails++; $display("FAIL basic_done got v=%b rdy=%b busy=%b want 0 1 0", a_rsp_valid, a_req_ready, a_busy); end
  endtask

  task automatic test_tick_gating();
    int en_cnt = 0;
    logic got = 1'b0, hold_ok = 1'b1, cs_ok = 1'b1;
    logic [37:0] snap;
    req_slot = 2'd1; req_valid_b = 1'b1; rsp_ready = 1'b0;
    for (int k = 0; k < 40 && !got; k++) begin
      tick = (k % 4 == 0);
      bus = tick ? 32'h12345678 : 32'hFFFF0000;
      snap = {b_req_ready, b_cs_n, b_rsp_valid, b_rsp_data, b_busy};
      cyc();
      if (tick) begin en_cnt++; req_valid_b = 1'b0; end
      else if (snap !== {b_req_ready, b_cs_n, b_rsp_valid, b_rsp_data, b_busy}) hold_ok = 1'b0;
      if (b_busy && !b_rsp_valid && b_cs_n !== 3'b101) cs_ok = 1'b0;
      if (b_rsp_valid) got = 1'b1;
    end
    tick = 1'b1;
    tests++; if (got !== 1'b1) begin fails++; $display("FAIL tick_rsp_timeout got %b want 1", got); end
    tests++; if (en_cnt != 5) begin fails++; $display("FAIL tick_latency got %0d want 5", en_cnt); end
    tests++; if (b_rsp_data !== 32'h12345678) begin fails++; $display("FAIL tick_data got %h want 12345678", b_rsp_data); end
    tests++; if (hold_ok !== 1'b1) begin fails++; $display("FAIL tick_hold got %b want 1", hold_ok); end
    tests++; if (cs_ok !== 1'b1) begin fails++; $display("FAIL tick_cs got %b want 1", cs_ok); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    tests++; if (b_req_ready !== 1'b1 || b_rsp_valid !== 1'b0) begin fails++; $display("FAIL tick_done got rdy=%b v=%b want 1 0", b_req_ready, b_rsp_valid); end
  endtask

  task automatic test_stall();
    logic stable_ok = 1'b1;
    req_slot = 2'd3; bus = 32'hA5A50F0F; req_valid_a = 1'b1; rsp_ready = 1'b0;
    cyc();
    req_valid_a = 1'b0;
    tests++; if (a_cs_n !== 4'b0111) begin fails++; $display("FAIL stall_cs got %b want 0111", a_cs_n); end
    cyc();
    cyc();
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hA5A50F0F) begin fails++; $display("FAIL stall_rsp got v=%b d=%h want 1 a5a50f0f", a_rsp_valid, a_rsp_data); end
    bus = 32'h0; req_slot = 2'd0; req_valid_a = 1'b1;
    for (int k = 0; k < 10; k++) begin
      cyc();
      if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'hA5A50F0F || a_req_ready !== 1'b0 || a_cs_n !== 4'b1111) stable_ok = 1'b0;
    end
    tests++; if (stable_ok !== 1'b1) begin fails++; $display("FAIL stall_stable got %b want 1", stable_ok); end
    ce = 1'b0; rsp_ready = 1'b1;
    cyc();
    tests++; if (a_rsp_valid !== 1'b1) begin fails++; $display("FAIL stall_ce_gate got %b want 1", a_rsp_valid); end
    ce = 1'b1;
    cyc();
    tests++; if (a_rsp_valid !== 1'b0 || a_req_ready !== 1'b1 || a_busy !== 1'b0) begin fails++; $display("FAIL stall_done got v=%b rdy=%b busy=%b want 0 1 0", a_rsp_valid, a_req_ready, a_busy); end
    req_valid_a = 1'b0; rsp_ready = 1'b0;
  endtask

  task automatic test_reset_abort();
    req_slot = 2'd1; bus = 32'hCAFE0001; req_valid_a = 1'b1;
    cyc();
    req_valid_a = 1'b0;
    tests++; if (a_cs_n !== 4'b1101) begin fails++; $display("FAIL abort_select_cs got %b want 1101", a_cs_n); end
    #2 rst_n = 1'b0;
    #1;
    tests++; if (a_cs_n !== 4'b1111 || a_rsp_valid !== 1'b0 || a_busy !== 1'b0) begin fails++; $display("FAIL abort_async got cs=%b v=%b busy=%b want 1111 0 0", a_cs_n, a_rsp_valid, a_busy); end
    cyc();
    rst_n = 1'b1;
    cyc();
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL abort_ready got %b want 1", a_req_ready); end
    req_slot = 2'd0; bus = 32'h0BADF00D; req_valid_a = 1'b1;
    cyc();
    req_valid_a = 1'b0;
    tests++; if (a_cs_n !== 4'b1110) begin fails++; $display("FAIL abort_next_cs got %b want 1110", a_cs_n); end
    cyc();
    cyc();
    tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== 32'h0BADF00D) begin fails++; $display("FAIL abort_next_rsp got v=%b d=%h want 1 0badf00d", a_rsp_valid, a_rsp_data); end
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
  endtask

  task automatic test_slot_range();
    req_slot = 2'd3; bus = 32'h5555AAAA; req_valid_b = 1'b1; rsp_ready = 1'b0;
    cyc();
    req_valid_b = 1'b0;
`ifdef REG_READER_SLOT_ERR_EN
    tests++; if (b_rsp_valid !== 1'b1 || b_rsp_err !== 1'b1) begin fails++; $display("FAIL range_err got v=%b e=%b want 1 1", b_rsp_valid, b_rsp_err); end
    tests++; if (b_rsp_data !== 32'h0 || b_cs_n !== 3'b111) begin fails++; $display("FAIL range_err_data got d=%h cs=%b want 0 111", b_rsp_data, b_cs_n); end
`else
    begin
      int n = 1;
      logic cs_ok = 1'b1;
      for (int k = 0; k < 10 && !b_rsp_valid; k++) begin
        if (b_cs_n !== 3'b111) cs_ok = 1'b0;
        cyc();
        n++;
      end
      tests++; if (b_rsp_valid !== 1'b1 || n != 5) begin fails++; $display("FAIL range_latency got v=%b n=%0d want 1 5", b_rsp_valid, n); end
      tests++; if (b_rsp_data !== 32'h5555AAAA) begin fails++; $display("FAIL range_data got %h want 5555aaaa", b_rsp_data); end
      tests++; if (cs_ok !== 1'b1) begin fails++; $display("FAIL range_cs got %b want 1", cs_ok); end
    end
`endif
    rsp_ready = 1'b1;
    cyc();
    rsp_ready = 1'b0;
    tests++; if (b_req_ready !== 1'b1) begin fails++; $display("FAIL range_done got %b want 1", b_req_ready); end
  endtask

  task automatic test_back_to_back();
    logic [3:0]  exp_cs;
    logic [31:0] exp_d;
    rsp_ready = 1'b1;
    for (int s = 0; s < 4; s++) begin
      exp_cs = ~(4'b0001 << s);
      exp_d  = 32'h10000000 + 32'(s) * 32'h00000101;
      req_slot = 2'(s); bus = exp_d; req_valid_a = 1'b1;
      cyc();
      req_valid_a = 1'b0;
      tests++; if (a_cs_n !== exp_cs) begin fails++; $display("FAIL b2b_cs slot %0d got %b want %b", s, a_cs_n, exp_cs); end
      cyc();
      cyc();
      tests++; if (a_rsp_valid !== 1'b1 || a_rsp_data !== exp_d) begin fails++; $display("FAIL b2b_rsp slot %0d got v=%b d=%h want 1 %h", s, a_rsp_valid, a_rsp_data, exp_d); end
      cyc();
    end
    rsp_ready = 1'b0;
    tests++; if (a_req_ready !== 1'b1) begin fails++; $display("FAIL b2b_idle got %b want 1", a_req_ready); end
    tests++; if (onehot_viol != 0) begin fails++; $display("FAIL onehot_cs got %0d violations want 0", onehot_viol); end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_tick_gating();
    test_stall();
    test_reset_abort();
    test_slot_range();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
